pic_uart_tx: RTL and testbench

//   Byte-wide UART transmitter peripheral fed by the PIC core's output-port write strobe.

---
 rtl/pic_uart_tx.sv | 155 +++++++++++++++
 tb/tb_pic_uart_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_uart_tx.sv
// pic_uart_tx: byte-wide UART transmitter fed by the PIC core's output-port write
// strobe. Writes land in a small FIFO; bytes leave as 8N1 frames, LSB first, with
// every bit slot lasting CLK_DIV enabled clock cycles. tx idles high.
module pic_uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          slot_end, pop, push;

    // Frame sequencer: next state, bit timer, shift register and line level.
    // NOTE: every signal gets a default at the top so no path leaves it unassigned
    // (otherwise a latch is inferred).
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        slot_end  = (timer_q == TIMER_LAST);
        if (ena) begin
            if (state_q == IDLE) begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = START;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    timer_d = '0;
                end
            end else if (!slot_end) begin
                timer_d = timer_q + 1'b1;
            end else begin
                timer_d = '0;
                case (state_q)
                    START: begin
                        state_d   = DATA;
                        tx_d      = shift_q[0];
                        bit_idx_d = '0;
                    end
                    DATA: begin
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            shift_d   = {1'b0, shift_q[7:1]};
                            tx_d      = shift_q[1];
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                    STOP: begin
                        // Chain straight into the next start bit when data is waiting.
                        if (!empty_q) begin
                            pop     = 1'b1;
                            state_d = START;
                            shift_d = mem_q[rd_ptr_q];
                            tx_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        busy_d = (state_d != IDLE);
    end

    // FIFO bookkeeping: a pop in the same cycle frees the slot a write into a full FIFO needs.
    always_comb begin
        push     = wr_en & ena & (~full_q | pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == COUNT_FULL);
        empty_d = (count_d == '0);
    end

    // FIFO storage: written only on an accepted push.
    // NOTE: the data array has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Control and output registers; reset drives the line high immediately.
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign busy  = busy_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_pic_uart_tx.sv
// tb_pic_uart_tx: directed stimulus for pic_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
// A queue-and-slot model predicts tx/busy/empty/full each cycle; an independent
// line decoder recovers bytes from tx for comparison against literal byte lists.
module tb_pic_uart_tx;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, busy, tx;

    int checks   = 0;
    int failures = 0;

    pic_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .busy(busy), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned m_q[$];
    bit           m_active = 1'b0;
    bit [9:0]     m_bits   = '1;
    int           m_slot   = 0;
    int           m_cnt    = 0;
    bit           m_ena_last = 1'b0;

    function automatic bit [9:0] frame_of(input byte unsigned b);
        return {1'b1, b, 1'b0};
    endfunction

    function void start_frame();
        m_bits   = frame_of(m_q.pop_front());
        m_active = 1'b1;
        m_slot   = 0;
        m_cnt    = 0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_active   = 1'b0;
            m_slot     = 0;
            m_cnt      = 0;
            m_ena_last = 1'b0;
        end else begin
            m_ena_last = ena;
            if (ena) begin
                if (!m_active) begin
                    if (m_q.size() > 0) start_frame();
                end else if (m_cnt == CLK_DIV - 1) begin
                    m_cnt = 0;
                    if (m_slot == 9) begin
                        if (m_q.size() > 0) start_frame();
                        else m_active = 1'b0;
                    end else begin
                        m_slot++;
                    end
                end else begin
                    m_cnt++;
                end
                if (wr_en && m_q.size() < DEPTH) m_q.push_back(wr_data);
            end
        end
    end

    // ---------------- compare process + line decoder ----------------
    bit           d_in    = 1'b0;
    int           d_phase = 0;
    int           d_idx   = 0;
    logic [7:0]   d_byte  = 8'h00;
    byte unsigned d_rx[$];

    initial forever begin
        @(negedge clk);
        check("cyc_tx",    {31'd0, tx},    {31'd0, (m_active ? m_bits[m_slot] : 1'b1)});
        check("cyc_busy",  {31'd0, busy},  {31'd0, m_active});
        check("cyc_empty", {31'd0, empty}, {31'd0, (m_q.size() == 0)});
        check("cyc_full",  {31'd0, full},  {31'd0, (m_q.size() == DEPTH)});
        if (!rst_n) begin
            d_in = 1'b0;
        end else if (!d_in) begin
            if (tx === 1'b0) begin
                d_in    = 1'b1;
                d_phase = 0;
            end
        end else if (m_ena_last) begin
            d_phase++;
            if (d_phase % CLK_DIV == CLK_DIV / 2) begin
                d_idx = d_phase / CLK_DIV;
                if (d_idx == 0) begin
                    check("rx_start_bit", {31'd0, tx}, 32'd0);
                end else if (d_idx <= 8) begin
                    d_byte[d_idx-1] = tx;
                end else begin
                    check("rx_stop_bit", {31'd0, tx}, 32'd1);
                    d_rx.push_back(d_byte);
                end
            end
            if (d_phase == 10 * CLK_DIV - 1) d_in = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    byte unsigned want[$];
    int           busy_cnt;
    int           full_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_tx_low(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        busy_cnt = 0;
        full_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0 && empty === 1'b1) begin
                done = 1'b1;
                break;
            end
            busy_cnt += (busy === 1'b1) ? 1 : 0;
            full_cnt += (full === 1'b1) ? 1 : 0;
            tick();
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic expect_rx(input string name);
        logic [31:0] v;
        check({name, "_count"}, d_rx.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            v = 'x;
            if (i < d_rx.size()) v = {24'd0, d_rx[i]};
            check(name, v, {24'd0, want[i]});
        end
        d_rx.delete();
    endtask

    // Guard against a hung run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    logic [9:0] pat55;
    int         low_cnt;

    initial begin
        ena = 1'b1;
        repeat (3) tick();
        check("reset_tx",    {31'd0, tx},    32'd1);
        check("reset_empty", {31'd0, empty}, 32'd1);
        check("reset_busy",  {31'd0, busy},  32'd0);
        check("reset_full",  {31'd0, full},  32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: single 0x55 frame, exact latency and bit pattern
        pat55   = 10'b1010101010;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        check("t1_tx_before_start", {31'd0, tx},    32'd1);
        check("t1_empty_fell",      {31'd0, empty}, 32'd0);
        tick();
        check("t1_tx_start_edge", {31'd0, tx}, 32'd0);
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % CLK_DIV == 1) check("t1_slot_level", {31'd0, tx}, {31'd0, pat55[c/CLK_DIV]});
            busy_cnt += (busy === 1'b1) ? 1 : 0;
            tick();
        end
        check("t1_busy_cycles", busy_cnt, 32'd40);
        check("t1_busy_end",  {31'd0, busy},  32'd0);
        check("t1_empty_end", {31'd0, empty}, 32'd1);
        check("t1_tx_end",    {31'd0, tx},    32'd1);
        want = '{8'h55};
        expect_rx("t1_rx");

        // 2: four back-to-back bytes, FIFO never fills
        write_byte(8'hA5);
        write_byte(8'h3C);
        write_byte(8'hFF);
        check("t2_full_mid", {31'd0, full}, 32'd0);
        write_byte(8'h00);
        check("t2_full_last", {31'd0, full}, 32'd0);
        wait_idle(400, "t2_drain");
        check("t2_busy_contiguous", busy_cnt, 32'd158);
        check("t2_full_never", full_cnt, 32'd0);
        want = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        expect_rx("t2_rx");

        // 3: fill while a frame is in flight, fifth write dropped
        write_byte(8'h7E);
        tick();
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        check("t3_full_at3", {31'd0, full}, 32'd0);
        write_byte(8'h04);
        check("t3_full_at4", {31'd0, full}, 32'd1);
        write_byte(8'h05);
        check("t3_full_after_drop", {31'd0, full}, 32'd1);
        wait_idle(600, "t3_drain");
        want = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04};
        expect_rx("t3_rx");

        // 4: pause 10 cycles during data bit 3 of 0xC3
        write_byte(8'hC3);
        wait_tx_low(10, "t4_start_seen");
        repeat (17) tick();
        ena     = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_frozen_tx",   {31'd0, tx},   32'd0);
            check("t4_frozen_busy", {31'd0, busy}, 32'd1);
        end
        ena   = 1'b1;
        wr_en = 1'b0;
        wait_idle(200, "t4_drain");
        check("t4_busy_remaining", busy_cnt, 32'd23);
        want = '{8'hC3};
        expect_rx("t4_rx");

        // 5: reset mid-frame with two bytes queued
        write_byte(8'h81);
        write_byte(8'h82);
        write_byte(8'h83);
        repeat (10) tick();
        check("t5_busy_pre",  {31'd0, busy},  32'd1);
        check("t5_empty_pre", {31'd0, empty}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t5_tx_async",    {31'd0, tx},    32'd1);
        check("t5_empty_async", {31'd0, empty}, 32'd1);
        check("t5_busy_async",  {31'd0, busy},  32'd0);
        repeat (2) tick();
        rst_n   = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            low_cnt += (tx !== 1'b1) ? 1 : 0;
            tick();
        end
        check("t5_quiet_after_reset", low_cnt, 32'd0);
        want = {};
        expect_rx("t5_rx_none");
        write_byte(8'h5A);
        wait_idle(100, "t5_drain");
        want = '{8'h5A};
        expect_rx("t5_rx");

        // 6: write lands on the STOP->START pop edge while full
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        write_byte(8'h55);
        check("t6_full_before", {31'd0, full}, 32'd1);
        repeat (36) tick();
        check("t6_in_stop",    {31'd0, tx},   32'd1);
        check("t6_full_stop",  {31'd0, full}, 32'd1);
        wr_en   = 1'b1;
        wr_data = 8'h66;
        tick();
        wr_en = 1'b0;
        check("t6_restart_tx", {31'd0, tx},   32'd0);
        check("t6_full_kept",  {31'd0, full}, 32'd1);
        wait_idle(400, "t6_drain");
        want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        expect_rx("t6_rx");

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
